// File: rtl/efuse_pkg.sv
// efuse_pkg: shared types and constants for the eFuse access scheduler.
//   state_e : scheduler FSM states
//   op_e    : latched operation kind (read one byte / program one bit)
//   EFUSE_AW, EFUSE_DW : macro address and read-data widths
package efuse_pkg;
    localparam int EFUSE_AW = 8;
    localparam int EFUSE_DW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_e;

    typedef enum logic {
        OP_RD  = 1'b0,
        OP_PGM = 1'b1
    } op_e;
endpackage

// File: rtl/efuse_rr_arb.sv
// efuse_rr_arb: requester 0 has strict priority, requesters 1..NREQ-1 share
// a round-robin slot.
//   clk, rst : clock, async active-high reset (pointer -> 1)
//   req_i    : request vector
//   upd_i    : grant was consumed this cycle; advance pointer past winner
//   gnt_o    : one-hot grant (combinational)
module efuse_rr_arb #(
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic            upd_i,
    output logic [NREQ-1:0] gnt_o
);
    localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;

    // Search starts at the pointer and wraps from NREQ-1 back to 1,
    // skipping index 0 which is handled by the priority path.
    always_comb begin
        int  idx;
        logic found;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        if (req_i[0]) begin
            gnt_o[0] = 1'b1;
        end else begin
            for (int k = 0; k < NREQ-1; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NREQ) idx = idx - (NREQ-1);
                if (!found && req_i[idx]) begin
                    gnt_o[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

    // Index-0 grants leave the rotation untouched.
    always_comb begin
        ptr_d = ptr_q;
        if (upd_i && !gnt_o[0]) begin
            for (int k = 1; k < NREQ; k++) begin
                if (gnt_o[k]) ptr_d = (k == NREQ-1) ? PW'(1) : PW'(k+1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= PW'(1);
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/efuse_access_sched.sv
// efuse_access_sched: arbitrates eFuse requesters and sequences the macro
// AEN/RDEN/PGMEN pins with programmable strobe lengths.
//   req_vld/req_wr/req_addr/req_rdy : per-requester request handshake
//   rsp_vld/rsp_err/rsp_rdata       : one-cycle completion to the winner
//   cfg_trd/cfg_tpgm/cfg_wr_lock    : strobe lengths (minus 1), program lock
//   efuse_*                         : macro pins
//   busy                            : FSM not in IDLE
module efuse_access_sched
    import efuse_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int TRD_W  = 6,
    parameter int TPGM_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_vld,
    input  logic [NREQ-1:0]          req_wr,
    input  logic [NREQ*EFUSE_AW-1:0] req_addr,
    output logic [NREQ-1:0]          req_rdy,
    output logic [NREQ-1:0]          rsp_vld,
    output logic                     rsp_err,
    output logic [EFUSE_DW-1:0]      rsp_rdata,
    input  logic [TRD_W-1:0]         cfg_trd,
    input  logic [TPGM_W-1:0]        cfg_tpgm,
    input  logic                     cfg_wr_lock,
    output logic                     efuse_aen_o,
    output logic                     efuse_rden_o,
    output logic                     efuse_pgmen_o,
    output logic [EFUSE_AW-1:0]      efuse_addr_o,
    input  logic [EFUSE_DW-1:0]      efuse_rdata_i,
    output logic                     busy
);
    localparam int LW = (TPGM_W > TRD_W) ? TPGM_W : TRD_W;

    state_e              state_q, state_d;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     own_q;
    op_e                 op_q;
    logic [LW-1:0]       len_q, cnt_q;
    logic [EFUSE_DW-1:0] rdata_q;
    logic                accept, locked_acc, strobe_last;
    logic                sel_wr;
    logic [EFUSE_AW-1:0] sel_addr;

    logic                aen_q, aen_d, rden_q, rden_d, pgmen_q, pgmen_d;
    logic                err_q, err_d, busy_q, busy_d;
    logic [NREQ-1:0]     rsp_vld_q, rsp_vld_d;
    logic [EFUSE_AW-1:0] addr_q, addr_d;

    efuse_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (req_vld),
        .upd_i (accept),
        .gnt_o (gnt)
    );

    assign req_rdy     = (state_q == IDLE && !rst) ? gnt : '0;
    assign accept      = |req_rdy;
    assign locked_acc  = accept && sel_wr && cfg_wr_lock;
    assign strobe_last = (state_q == STROBE) && (cnt_q == len_q);

    always_comb begin
        sel_wr   = 1'b0;
        sel_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_wr   = req_wr[i];
                sel_addr = req_addr[EFUSE_AW*i +: EFUSE_AW];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state; a locked program skips the macro entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = locked_acc ? HOLD : SETUP;
            SETUP:   state_d = STROBE;
            STROBE:  if (strobe_last) state_d = HOLD;
            default: state_d = IDLE;
        endcase
    end

    // Output next-values, registered below so every macro pin and response
    // comes straight from a flop. IDLE->HOLD only happens on a locked
    // program, which is the sole source of rsp_err.
    always_comb begin
        aen_d     = (state_d == SETUP) || (state_d == STROBE);
        rden_d    = (state_d == STROBE) && (op_q == OP_RD);
        pgmen_d   = (state_d == STROBE) && (op_q == OP_PGM);
        addr_d    = (accept && !locked_acc) ? sel_addr : addr_q;
        rsp_vld_d = '0;
        if (state_d == HOLD) rsp_vld_d = (state_q == IDLE) ? req_rdy : own_q;
        err_d     = (state_d == HOLD) && (state_q == IDLE);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aen_q     <= 1'b0;
            rden_q    <= 1'b0;
            pgmen_q   <= 1'b0;
            addr_q    <= '0;
            rsp_vld_q <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            aen_q     <= aen_d;
            rden_q    <= rden_d;
            pgmen_q   <= pgmen_d;
            addr_q    <= addr_d;
            rsp_vld_q <= rsp_vld_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    // Request context is captured at accept so config writes during an
    // operation cannot stretch or shorten its strobe. The up-counter is as
    // wide as the longest length, so a max config runs 2^W cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own_q   <= '0;
            op_q    <= OP_RD;
            len_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                own_q <= req_rdy;
                op_q  <= sel_wr ? OP_PGM : OP_RD;
                len_q <= sel_wr ? LW'(cfg_tpgm) : LW'(cfg_trd);
            end
            if (state_q == STROBE) cnt_q <= strobe_last ? '0 : cnt_q + 1'b1;
            if (strobe_last && op_q == OP_RD) rdata_q <= efuse_rdata_i;
        end
    end

    assign efuse_aen_o   = aen_q;
    assign efuse_rden_o  = rden_q;
    assign efuse_pgmen_o = pgmen_q;
    assign efuse_addr_o  = addr_q;
    assign rsp_vld       = rsp_vld_q;
    assign rsp_err       = err_q;
    assign rsp_rdata     = rdata_q;
    assign busy          = busy_q;
endmodule

// File: doc/efuse_access_sched.md
# efuse_access_sched

Byte/bit-level access scheduler for the 256-bit eFuse macro. Sits between the eFuse macro pins and several access requesters: PMU autoload, register-driven read, register-driven program, and debug. It arbitrates the requesters and sequences AEN/RDEN/PGMEN with programmable strobe widths. It returns read data or completion status to the winning requester.

## Interface
- NREQ, 3: number of requesters. Index 0 is the autoload port.
- TRD_W, 6: width of the read-strobe length config.
- TPGM_W, 10: width of the program-strobe length config.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_vld  in  NREQ  request valid per requester; held until accepted
- req_wr  in  NREQ  1 = program one bit, 0 = read one byte
- req_addr  in  NREQ*8  address, requester i in bits [8i+7:8i]; bit address for program, byte-aligned address for read
- req_rdy  out  NREQ  one-hot accept; request i is taken when req_vld[i] & req_rdy[i]
- rsp_vld  out  NREQ  one-cycle completion pulse to the originating requester
- rsp_err  out  1  valid with rsp_vld; program rejected by lock
- rsp_rdata  out  8  read byte, valid with rsp_vld (shared bus)
- cfg_trd  in  TRD_W  read strobe length minus 1
- cfg_tpgm  in  TPGM_W  program strobe length minus 1
- cfg_wr_lock  in  1  1 = program requests are rejected
- efuse_aen_o  out  1  macro address enable
- efuse_rden_o  out  1  macro read strobe
- efuse_pgmen_o  out  1  macro program strobe
- efuse_addr_o  out  8  macro address
- efuse_rdata_i  in  8  macro read data
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- Accept happens only in IDLE. req_rdy is combinational from req_vld and the arbiter state, and is all-zero outside IDLE.
- Arbitration:
  - req 0 has strict priority.
  - Indices 1..NREQ-1 are round-robin. The pointer advances past the winner on every accept of a non-zero index and is unchanged by index-0 accepts.
  - After reset the pointer favours index 1.
- On accept, the following are latched: requester index, op, addr, cfg_trd/cfg_tpgm, and cfg_wr_lock. Later config changes do not affect an operation in flight.
- Locked program (wr & lock):
  - IDLE -> HOLD directly with no macro activity.
  - rsp_vld pulses with rsp_err=1.
- Normal operation:
  - IDLE -> SETUP: efuse_aen_o=1, efuse_addr_o=latched addr, for 1 cycle.
  - SETUP -> STROBE: aen stays 1 and rden (read) or pgmen (program) is 1. Length is cfg_trd+1 or cfg_tpgm+1 cycles, counted by an up-counter compared against the latched length.
  - STROBE -> HOLD: strobe low, aen low, addr held for 1 cycle. rsp_vld pulses. rsp_err=0.
  - HOLD -> IDLE.
- Read data is captured from efuse_rdata_i on the last STROBE cycle into a register. rsp_rdata holds its value until the next read capture.
- efuse_addr_o holds its last value in IDLE.
- rden and pgmen are never high simultaneously.

## Timing
- Reset values: req_rdy=0, rsp_vld=0, rsp_err=0, rsp_rdata=0, all efuse_*_o=0, busy=0, state=IDLE, counter=0, RR pointer=1.
- Timing is relative to the accept edge at cycle 0:
  - SETUP is cycle 1.
  - STROBE is cycles 2..L+1, with L = cfg+1.
  - HOLD and rsp_vld are at cycle L+2.
  - The next accept is possible at cycle L+3.
- Read latency is cfg_trd+3. Program latency is cfg_tpgm+3. A locked-program response comes at cycle 1.
- cfg=0 gives a 1-cycle strobe. Max cfg gives 2^W strobe cycles. The counter must not wrap early.
- Simultaneous requests: index 0 always wins. The others win in rotation. A requester dropping req_vld before accept is legal, and it is ignored.
- Reset asserted mid-operation: all strobes drop asynchronously and no rsp_vld is issued. The aborted request is not retried.
- All outputs are registered, except req_rdy.

## Structure
- Package efuse_pkg holds:
  - the state enum: IDLE, SETUP, STROBE, HOLD
  - the op enum: OP_RD, OP_PGM
  - the constants EFUSE_AW=8 and EFUSE_DW=8
- Sub-module efuse_rr_arb (NREQ): priority-0 plus round-robin grant with a pointer update enable.

## Test plan
- Single read: req 1 reads addr 0x10, cfg_trd=3, macro drives 0xA5. rden is high for exactly 4 cycles. rsp_vld[1] at cycle 6. rsp_rdata=0xA5.
- Program: req 2 programs bit 0x37, cfg_tpgm=9, unlocked. pgmen is high for 10 cycles with aen=1 and addr=0x37. rsp_vld[2] at cycle 12, err=0.
- Locked program: cfg_wr_lock=1, req 1 programs. No aen/pgmen activity. rsp_vld[1] at cycle 1 with rsp_err=1.
- Arbitration: req 0, 1 and 2 all held valid. Grant order is 0, 1, 2. With 1 and 2 re-requesting, the order is 1, 2, 1, 2. Req 0 re-asserted mid-sequence wins the next IDLE.
- Boundary: cfg_trd=0 gives a 1-cycle rden and rsp at cycle 3. cfg_tpgm=1023 gives exactly 1024 pgmen cycles.
- Reset mid-STROBE: assert rst during pgmen. pgmen and aen drop in the same cycle. No rsp_vld follows. The next request after reset completes normally.
